// File: rtl/mem_bank_arbiter_pkg.sv
// Shared types and constants for the two-requester banked-memory arbiter.
package mem_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;
  localparam int BANK_W     = 8;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_COMPLETE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE     = ST_IDLE,
    S_ISSUE    = ST_ISSUE,
    S_COMPLETE = ST_COMPLETE
  } state_t;

  // Saturating 8-bit increment for the completion counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mem_bank_arbiter_if.sv
// Client-side handshake and memory-side bus of the arbiter; slave = arbiter view.
interface mem_bank_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in, mem_data_out;
  logic              busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    output ack0, ack1, rdata0, rdata1, mem_read, mem_write, mem_address, mem_data_in, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  ack0, ack1, rdata0, rdata1, mem_read, mem_write, mem_address, mem_data_in, busy
  );
endinterface

// File: rtl/mem_bank_arbiter_rr_arb2.sv
// Two-way round-robin pick; owns the last_grant register (resets to 1 so requester 0 wins the first tie).
module rr_arb2 (
  input  logic clk,
  input  logic reset_L,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic grant_valid,
  output logic grant_id
);

  logic last_grant_q;

  assign grant_valid = req0 | req1;
  // Lone requester wins; on a tie the one that did not win last time goes.
  assign grant_id    = req1 & (~req0 | ~last_grant_q);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)                 last_grant_q <= 1'b1;
    else if (take && grant_valid) last_grant_q <= grant_id;
  end

endmodule

// File: rtl/mem_bank_arbiter.sv
// Round-robin arbiter sharing one banked 32x16 memory between two requesters via IDLE/ISSUE/COMPLETE.
// Define MEM_ARB_STATS_EN to add saturating per-requester completion counters cnt0/cnt1.
module mem_bank_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_L,
  mem_bank_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [7:0]        cnt0,
  output logic [7:0]        cnt1
`endif
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_t                 state_q, state_d;
  cmd_t                   cmd_q, cmd_d, cmd_sel;
  logic                   win_q, win_d;
  logic                   rd_q, rd_d, wr_q, wr_d;
  logic                   busy_q, busy_d;
  logic [1:0]             ack_q, ack_d, rdata_ld;
  logic [1:0][DATA_W-1:0] rdata_q;
  logic                   grant_valid, grant_id, grant_take;

  rr_arb2 u_arb (
    .clk         (clk),
    .reset_L     (reset_L),
    .req0        (bus.req0),
    .req1        (bus.req1),
    .take        (grant_take),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign cmd_sel = grant_id ? {bus.we1, bus.addr1, bus.wdata1}
                            : {bus.we0, bus.addr0, bus.wdata0};

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Outputs are registered, so each branch computes what the next state drives.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    win_d      = win_q;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    busy_d     = 1'b0;
    ack_d      = '0;
    rdata_ld   = '0;
    grant_take = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          grant_take = 1'b1;
          win_d      = grant_id;
          cmd_d      = cmd_sel;
          wr_d       = cmd_sel.we;
          rd_d       = ~cmd_sel.we;
          busy_d     = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy_d          = 1'b1;
        ack_d[win_q]    = 1'b1;
        rdata_ld[win_q] = ~cmd_q.we;
        state_d         = S_COMPLETE;
      end
      S_COMPLETE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cmd_q   <= '0;
      win_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      cmd_q  <= cmd_d;
      win_q  <= win_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      busy_q <= busy_d;
      ack_q  <= ack_d;
      // Memory read is asynchronous, so data is captured on the same edge the ack rises.
      for (int i = 0; i < 2; i++)
        if (rdata_ld[i]) rdata_q[i] <= bus.mem_data_out;
    end
  end

  assign bus.mem_read    = rd_q;
  assign bus.mem_write   = wr_q;
  assign bus.mem_address = cmd_q.addr;
  assign bus.mem_data_in = cmd_q.wdata;
  assign bus.busy        = busy_q;
  assign bus.ack0        = ack_q[0];
  assign bus.ack1        = ack_q[1];
  assign bus.rdata0      = rdata_q[0];
  assign bus.rdata1      = rdata_q[1];

`ifdef MEM_ARB_STATS_EN
  logic [1:0][7:0] cnt_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)                   cnt_q        <= '0;
    else if (state_q == S_COMPLETE) cnt_q[win_q] <= sat_inc8(cnt_q[win_q]);
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
`endif

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Bench for mem_bank_arbiter: four byte banks, transaction-level reference model, directed + random traffic.
module tb_mem_bank_arbiter;
  import mem_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  mem_bank_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  logic [1:0]         req_v   = '0;
  logic [1:0]         we_v    = '0;
  logic [1:0][AW-1:0] addr_v  = '0;
  logic [1:0][DW-1:0] wdata_v = '0;

  assign bus.req0   = req_v[0];
  assign bus.req1   = req_v[1];
  assign bus.we0    = we_v[0];
  assign bus.we1    = we_v[1];
  assign bus.addr0  = addr_v[0];
  assign bus.addr1  = addr_v[1];
  assign bus.wdata0 = wdata_v[0];
  assign bus.wdata1 = wdata_v[1];

`ifdef MEM_ARB_STATS_EN
  logic [7:0] cnt0, cnt1;
`endif

  mem_bank_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
`ifdef MEM_ARB_STATS_EN
    ,
    .cnt0    (cnt0),
    .cnt1    (cnt1)
`endif
  );

  // Four byte-wide banks on common address/strobe, asynchronous read.
  logic [DW-1:0] mdo;
  assign bus.mem_data_out = mdo;
  for (genvar b = 0; b < DW/8; b++) begin : g_bank
    logic [7:0] arr [16];
    initial for (int i = 0; i < 16; i++) arr[i] = 8'h00;
    always @(posedge clk) if (bus.mem_write) arr[bus.mem_address] <= bus.mem_data_in[8*b +: 8];
    assign mdo[8*b +: 8] = arr[bus.mem_address];
  end

  // ---------------- reference model ----------------
  // Transaction view: a grant starts a 2-cycle job (strobe cycle, then ack cycle).
  logic [DW-1:0]      mm [16];
  int                 m_ph;      // cycles since grant: 0 none, 1 strobe, 2 ack
  logic               m_id, m_we, m_lg;
  logic [AW-1:0]      m_addr;
  logic [DW-1:0]      m_wdata;
  logic [1:0][DW-1:0] m_rd;
  int                 m_cnt [2];

  initial for (int i = 0; i < 16; i++) mm[i] = '0;

  function automatic logic pick(input logic [1:0] r, input logic lg);
    if (r == 2'b11) return ~lg;
    return r[1];
  endfunction

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      m_ph <= 0; m_lg <= 1'b1; m_id <= 1'b0; m_we <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_rd <= '0;
      m_cnt[0] <= 0; m_cnt[1] <= 0;
    end else if (m_ph == 0) begin
      if (req_v != 2'b00) begin
        m_id    <= pick(req_v, m_lg);
        m_lg    <= pick(req_v, m_lg);
        m_we    <= we_v[pick(req_v, m_lg)];
        m_addr  <= addr_v[pick(req_v, m_lg)];
        m_wdata <= wdata_v[pick(req_v, m_lg)];
        m_ph    <= 1;
      end
    end else if (m_ph == 1) begin
      m_ph <= 2;
      if (m_we) mm[m_addr]   <= m_wdata;
      else      m_rd[m_id]   <= mm[m_addr];
    end else begin
      m_ph <= 0;
      if (m_cnt[m_id] < 255) m_cnt[m_id] <= m_cnt[m_id] + 1;
    end
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",        64'(bus.busy),        64'(m_ph != 0));
      chk("mem_write",   64'(bus.mem_write),   64'(m_ph == 1 && m_we));
      chk("mem_read",    64'(bus.mem_read),    64'(m_ph == 1 && !m_we));
      chk("ack0",        64'(bus.ack0),        64'(m_ph == 2 && m_id == 1'b0));
      chk("ack1",        64'(bus.ack1),        64'(m_ph == 2 && m_id == 1'b1));
      chk("mem_address", 64'(bus.mem_address), 64'(m_addr));
      chk("mem_data_in", 64'(bus.mem_data_in), 64'(m_wdata));
      chk("rdata0",      64'(bus.rdata0),      64'(m_rd[0]));
      chk("rdata1",      64'(bus.rdata1),      64'(m_rd[1]));
`ifdef MEM_ARB_STATS_EN
      chk("cnt0",        64'(cnt0),            64'(m_cnt[0]));
      chk("cnt1",        64'(cnt1),            64'(m_cnt[1]));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_cmd(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we_v[i] = w; addr_v[i] = a; wdata_v[i] = d; req_v[i] = 1'b1;
  endtask

  task automatic rand_cmd(input int i);
    set_cmd(i, 1'($urandom), AW'($urandom_range(0, 15)), $urandom);
  endtask

  // Wait (bounded) for acks of the requesters in 'want'; each drops req on its ack cycle.
  task automatic wait_acks(input logic [1:0] want, output int c0, output int c1);
    logic [1:0] got;
    got = '0; c0 = -1; c1 = -1;
    for (int c = 1; c <= 20 && got != want; c++) begin
      @(negedge clk);
      if (want[0] && !got[0] && bus.ack0) begin got[0] = 1'b1; c0 = c; req_v[0] = 1'b0; end
      if (want[1] && !got[1] && bus.ack1) begin got[1] = 1'b1; c1 = c; req_v[1] = 1'b0; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_L = 1'b0; req_v = '0;
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic rand_step();
    logic [1:0] ak;
    ak = {bus.ack1, bus.ack0};
    for (int i = 0; i < 2; i++) begin
      if (req_v[i]) begin
        if (ak[i]) begin
          if ($urandom_range(0, 1) == 1) rand_cmd(i);
          else req_v[i] = 1'b0;
        end else if ($urandom_range(0, 39) == 0) req_v[i] = 1'b0;   // occasional early drop
      end else if ($urandom_range(0, 2) == 0) rand_cmd(i);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, id;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy",  64'(bus.busy),        64'(0));
    chk("rst_wr",    64'(bus.mem_write),   64'(0));
    chk("rst_rd",    64'(bus.mem_read),    64'(0));
    chk("rst_ack",   64'({bus.ack1, bus.ack0}), 64'(0));
    chk("rst_addr",  64'(bus.mem_address), 64'(0));
    chk("rst_rdata", 64'(bus.rdata0 | bus.rdata1), 64'(0));
    reset_L = 1'b1;
    chk_en  = 1'b1;

    // 1: write DEADBEEF to word 3.
    @(negedge clk);
    set_cmd(0, 1'b1, 4'h3, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_wr",    64'(bus.mem_write),   64'(1));
    chk("t1_addr",  64'(bus.mem_address), 64'(4'h3));
    chk("t1_data",  64'(bus.mem_data_in), 64'(32'hDEADBEEF));
    chk("t1_busy",  64'(bus.busy),        64'(1));
    chk("t1_noack", 64'(bus.ack0),        64'(0));
    @(negedge clk);
    chk("t1_wr_off", 64'(bus.mem_write), 64'(0));
    chk("t1_ack",    64'(bus.ack0),      64'(1));
    req_v[0] = 1'b0;
    @(negedge clk);
    chk("t1_ack_off", 64'(bus.ack0), 64'(0));
    chk("t1_idle",    64'(bus.busy), 64'(0));

    // 2: read it back through requester 1.
    set_cmd(1, 1'b0, 4'h3, 32'h0);
    @(negedge clk);
    chk("t2_rd", 64'(bus.mem_read), 64'(1));
    @(negedge clk);
    chk("t2_ack",   64'(bus.ack1),   64'(1));
    chk("t2_rdata", 64'(bus.rdata1), 64'(32'hDEADBEEF));
    req_v[1] = 1'b0;
    @(negedge clk);

    // 3: tie straight after reset -> 0 first, then 1.
    do_reset();
    set_cmd(0, 1'b1, 4'h7, 32'h0BADF00D);
    set_cmd(1, 1'b0, 4'h7, 32'h0);
    wait_acks(2'b11, c0, c1);
    chk("t3_lat0",  64'(c0), 64'(2));
    chk("t3_lat1",  64'(c1), 64'(5));
    chk("t3_rdata", 64'(bus.rdata1), 64'(32'h0BADF00D));

    // 4: both held for 8 transactions -> strict alternation starting with 0.
    rand_cmd(0);
    rand_cmd(1);
    for (int t = 0; t < 8; t++) begin
      id = -1;
      for (int c = 0; c < 10 && id < 0; c++) begin
        @(negedge clk);
        if (bus.ack0) id = 0;
        else if (bus.ack1) id = 1;
      end
      chk("t4_fair", 64'(id), 64'(t % 2));
      if (id >= 0) rand_cmd(id);
    end
    req_v = '0;
    repeat (4) @(negedge clk);

    // 5: reset during ISSUE of a write aborts it.
    set_cmd(0, 1'b1, 4'h5, 32'hA5A5A5A5);
    wait_acks(2'b01, c0, c1);
    chk("t5_pre_lat", 64'(c0), 64'(2));
    @(negedge clk);
    set_cmd(0, 1'b1, 4'h5, 32'h12345678);
    @(negedge clk);
    chk("t5_issue", 64'(bus.mem_write), 64'(1));
    #2 reset_L = 1'b0;
    #1;
    chk("t5_wr_drop", 64'(bus.mem_write), 64'(0));
    chk("t5_busy",    64'(bus.busy),      64'(0));
    req_v = '0;
    @(negedge clk);
    chk("t5_noack", 64'(bus.ack0), 64'(0));
    reset_L = 1'b1;
    @(negedge clk);
    set_cmd(1, 1'b0, 4'h5, 32'h0);
    wait_acks(2'b10, c0, c1);
    chk("t5_lat",      64'(c1),         64'(2));
    chk("t5_readback", 64'(bus.rdata1), 64'(32'hA5A5A5A5));

    // Random traffic against the model.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      rand_step();
    end
    req_v = '0;
    repeat (4) @(negedge clk);

    // 6: 300 reads by requester 0 saturate its counter.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      set_cmd(0, 1'b0, AW'($urandom_range(0, 15)), 32'h0);
      wait_acks(2'b01, c0, c1);
      if (n == 0) chk("t6_lat", 64'(c0), 64'(2));
    end
    repeat (2) @(negedge clk);
`ifdef MEM_ARB_STATS_EN
    chk("t6_cnt0", 64'(cnt0), 64'(8'hFF));
    chk("t6_cnt1", 64'(cnt1), 64'(8'h00));
`endif

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
